wb_reg_bridge: RTL and testbench

Parametrised Wishbone classic-cycle slave that bridges a 32-bit-class bus onto a generic peripheral register port, for use in front of BLDC, timer and similar register-mapped blocks. It supersedes the fixed single-cycle bridge with several additions:
- byte-lane write strobes;
- configurable register read latency;
- address-range checking with a Wishbone error response;
- clean handling of master aborts.

---
 rtl/wb_reg_bridge.sv | 169 ++++++++++++++++
 tb/tb_wb_reg_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_bridge.sv
// rtl/wb_reg_bridge.sv - Wishbone classic slave bridged onto a peripheral register port
// Decodes byte addresses to word registers, with programmable read latency and error termination.
module wb_reg_bridge #(
    parameter int WB_AW    = 32,
    parameter int WB_DW    = 32,
    parameter int REG_AW   = 6,
    parameter int NUM_REGS = 64,
    parameter int RD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [WB_DW/8-1:0]    wb_sel_i,
    input  logic [WB_AW-1:0]      wb_adr_i,
    input  logic [WB_DW-1:0]      wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [WB_DW-1:0]      wb_dat_o,
    output logic [REG_AW-1:0]     reg_addr_o,
    output logic [WB_DW-1:0]      reg_wdata_o,
    output logic [WB_DW/8-1:0]    reg_wstrb_o,
    output logic                  reg_wen_o,
    output logic                  reg_ren_o,
    input  logic [WB_DW-1:0]      reg_rdata_i
);

    localparam int SW  = WB_DW / 8;
    localparam int OFS = $clog2(SW);
    localparam logic [REG_AW:0] NUM_REGS_W = (REG_AW + 1)'(NUM_REGS);
    localparam logic [2:0]      WAIT_INIT  = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam bit              ZERO_LAT   = (RD_LAT == 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_RESP  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic [WB_DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;
    logic [WB_DW-1:0]    dat_q, dat_d;

    logic                req;
    logic                in_range;
    logic [REG_AW-1:0]   word_idx;

    assign req      = wb_cyc_i & wb_stb_i;
    assign word_idx = wb_adr_i[OFS +: REG_AW];
    assign in_range = ((wb_adr_i >> (OFS + REG_AW)) == '0) &&
                      ({1'b0, word_idx} < NUM_REGS_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        dat_d   = dat_q;
        abort_d = abort_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = word_idx;
                    wdata_d = wb_dat_i;
                    wstrb_d = wb_sel_i;
                    abort_d = 1'b0;
                    if (!in_range) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (wb_we_i) begin
                        state_d = S_WR;
                        wen_d   = |wb_sel_i;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_RD;
                        ren_d   = 1'b1;
                    end
                end
            end
            S_WR:  state_d = S_IDLE;
            S_ERR: state_d = S_IDLE;
            S_RD: begin
                // A master that drops cyc mid-read forfeits the ack but the read still runs out
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (ZERO_LAT) begin
                    dat_d   = reg_rdata_i;
                    state_d = S_RESP;
                    ack_d   = !abort_d;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    dat_d   = reg_rdata_i;
                    state_d = S_RESP;
                    ack_d   = !abort_d;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            dat_q   <= dat_d;
        end
    end

    // Terminations are qualified live so a master leaving the cycle never sees a stray ack/err
    assign wb_ack_o    = ack_q & req;
    assign wb_err_o    = err_q & req;
    assign wb_dat_o    = dat_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;
    assign reg_wen_o   = wen_q;
    assign reg_ren_o   = ren_q;

endmodule

// File: tb/tb_wb_reg_bridge.sv
// tb/tb_wb_reg_bridge.sv - directed bench for wb_reg_bridge against a transaction scheduling model
// Two instances share one bus trace: A (64 regs, latency 3) and B (48 regs, latency 0).
module tb_wb_reg_bridge;

    localparam int N = 120;

    logic clk;
    logic rst_n;
    logic wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i, reg_rdata_i;

    logic [1:0]  ack_o, err_o, wen_o, ren_o;
    logic [31:0] dat_o   [2];
    logic [5:0]  addr_o  [2];
    logic [31:0] wdata_o [2];
    logic [3:0]  wstrb_o [2];

    wb_reg_bridge #(.WB_AW(32), .WB_DW(32), .REG_AW(6), .NUM_REGS(64), .RD_LAT(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]), .wb_dat_o(dat_o[0]),
        .reg_addr_o(addr_o[0]), .reg_wdata_o(wdata_o[0]), .reg_wstrb_o(wstrb_o[0]),
        .reg_wen_o(wen_o[0]), .reg_ren_o(ren_o[0]), .reg_rdata_i(reg_rdata_i)
    );

    wb_reg_bridge #(.WB_AW(32), .WB_DW(32), .REG_AW(6), .NUM_REGS(48), .RD_LAT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]), .wb_dat_o(dat_o[1]),
        .reg_addr_o(addr_o[1]), .reg_wdata_o(wdata_o[1]), .reg_wstrb_o(wstrb_o[1]),
        .reg_wen_o(wen_o[1]), .reg_ren_o(ren_o[1]), .reg_rdata_i(reg_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          s_rst [N];
    bit          s_cyc [N];
    bit          s_stb [N];
    bit          s_we  [N];
    logic [3:0]  s_sel [N];
    logic [31:0] s_adr [N];
    logic [31:0] s_dat [N];
    logic [31:0] s_rdata [N];
    int          len;

    bit          e_ack   [2][N];
    bit          e_err   [2][N];
    bit          e_wen   [2][N];
    bit          e_ren   [2][N];
    logic [5:0]  e_addr  [2][N];
    logic [31:0] e_wdata [2][N];
    logic [3:0]  e_wstrb [2][N];
    logic [31:0] e_dat   [2][N];

    int n_cmp;
    int n_bad;
    int cur;
    bit running;

    task automatic put(input bit rst, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        s_rst[len] = rst; s_cyc[len] = cyc; s_stb[len] = stb; s_we[len] = we;
        s_adr[len] = adr; s_dat[len] = dat; s_sel[len] = sel;
        len++;
    endtask

    task automatic idle(input int k);
        repeat (k) put(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic rst_cycles(input int k);
        repeat (k) put(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int hold);
        repeat (hold) put(1'b1, 1'b1, 1'b1, we, adr, dat, sel);
    endtask

    // Every accepted request schedules its pulses and held values relative to its acceptance cycle
    task automatic build_model(input int k, input int nregs, input int lat);
        int free;
        logic [31:0] a;
        bit inr, ok;
        free = 0;
        for (int n = 0; n < N; n++) begin
            e_ack[k][n] = 0; e_err[k][n] = 0; e_wen[k][n] = 0; e_ren[k][n] = 0;
            e_addr[k][n] = '0; e_wdata[k][n] = '0; e_wstrb[k][n] = '0; e_dat[k][n] = '0;
        end
        for (int n = 0; n < N - 8; n++) begin
            if (!s_rst[n]) begin
                for (int m = n; m < N; m++) begin
                    e_ack[k][m] = 0; e_err[k][m] = 0; e_wen[k][m] = 0; e_ren[k][m] = 0;
                    e_addr[k][m] = '0; e_wdata[k][m] = '0; e_wstrb[k][m] = '0; e_dat[k][m] = '0;
                end
                free = n + 1;
            end else if (n >= free && s_cyc[n] && s_stb[n]) begin
                a = s_adr[n];
                for (int m = n + 1; m < N; m++) begin
                    e_addr[k][m]  = a[7:2];
                    e_wdata[k][m] = s_dat[n];
                    e_wstrb[k][m] = s_sel[n];
                end
                inr = ((a >> 8) == 32'h0) && (int'(a[7:2]) < nregs);
                if (!inr) begin
                    e_err[k][n+1] = s_cyc[n+1] && s_stb[n+1];
                    free = n + 2;
                end else if (s_we[n]) begin
                    e_wen[k][n+1] = (s_sel[n] != 4'h0);
                    e_ack[k][n+1] = s_cyc[n+1] && s_stb[n+1];
                    free = n + 2;
                end else begin
                    e_ren[k][n+1] = 1;
                    for (int m = n + 2 + lat; m < N; m++) e_dat[k][m] = s_rdata[n+1+lat];
                    ok = s_stb[n+2+lat];
                    for (int j = n + 1; j <= n + 2 + lat; j++) ok = ok && s_cyc[j];
                    e_ack[k][n+2+lat] = ok;
                    free = n + 3 + lat;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    task automatic pins(input int n);
        case (n)
            1:  begin chk("pin_rst_dat", n, dat_o[0], 32'h0); chk("pin_rst_ack", n, 32'(ack_o[0]), 32'h0); end
            4:  begin
                chk("pin_w1_wen", n, 32'(wen_o[0]), 32'h1);
                chk("pin_w1_addr", n, 32'(addr_o[0]), 32'h4);
                chk("pin_w1_wdata", n, wdata_o[0], 32'hA5A5_1234);
                chk("pin_w1_wstrb", n, 32'(wstrb_o[0]), 32'hF);
                chk("pin_w1_ack", n, 32'(ack_o[0]), 32'h1);
            end
            5:  begin chk("pin_w1_ack_off", n, 32'(ack_o[0]), 32'h0); chk("pin_w1_wen_off", n, 32'(wen_o[0]), 32'h0); end
            7:  begin chk("pin_lane_wstrb", n, 32'(wstrb_o[0]), 32'h4); chk("pin_lane_wen", n, 32'(wen_o[0]), 32'h1); end
            9:  begin chk("pin_sel0_wen", n, 32'(wen_o[0]), 32'h0); chk("pin_sel0_ack", n, 32'(ack_o[0]), 32'h1); end
            12: begin
                chk("pin_oor_err", n, 32'(err_o[0]), 32'h1);
                chk("pin_oor_ren", n, 32'(ren_o[0]), 32'h0);
                chk("pin_oor_dat", n, dat_o[0], 32'h0);
            end
            14: begin chk("pin_hi_err", n, 32'(err_o[0]), 32'h1); chk("pin_hi_wen", n, 32'(wen_o[0]), 32'h0); end
            17: begin chk("pin_nregs_err_b", n, 32'(err_o[1]), 32'h1); chk("pin_idx50_ren_a", n, 32'(ren_o[0]), 32'h1); end
            25: chk("pin_lat3_ren", n, 32'(ren_o[0]), 32'h1);
            28: chk("pin_lat3_early", n, 32'(ack_o[0]), 32'h0);
            29: begin chk("pin_lat3_ack", n, 32'(ack_o[0]), 32'h1); chk("pin_lat3_dat", n, dat_o[0], 32'hDEAD_BEEF); end
            34: begin chk("pin_lat0_ack", n, 32'(ack_o[1]), 32'h1); chk("pin_lat0_dat", n, dat_o[1], 32'hCAFE_F00D); end
            40: chk("pin_b2b_wen1", n, 32'(wen_o[0]), 32'h1);
            41: chk("pin_b2b_gap", n, 32'(wen_o[0]), 32'h0);
            42: chk("pin_b2b_wen2", n, 32'(wen_o[0]), 32'h1);
            44: chk("pin_b2b_ren", n, 32'(ren_o[0]), 32'h1);
            56: chk("pin_abort_ack", n, 32'(ack_o[0]), 32'h0);
            63: chk("pin_after_abort_ack", n, 32'(ack_o[0]), 32'h1);
            67: chk("pin_pre_rst_addr", n, 32'(addr_o[0]), 32'h5);
            68: begin
                chk("pin_rst_addr", n, 32'(addr_o[0]), 32'h0);
                chk("pin_rst_wdata", n, wdata_o[0], 32'h0);
                chk("pin_rst_dat", n, dat_o[0], 32'h0);
            end
            81: begin chk("pin_drop_wen", n, 32'(wen_o[0]), 32'h1); chk("pin_drop_ack", n, 32'(ack_o[0]), 32'h0); end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (running) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ack_%0d", k), cur, 32'(ack_o[k]), 32'(e_ack[k][cur]));
                chk($sformatf("err_%0d", k), cur, 32'(err_o[k]), 32'(e_err[k][cur]));
                chk($sformatf("wen_%0d", k), cur, 32'(wen_o[k]), 32'(e_wen[k][cur]));
                chk($sformatf("ren_%0d", k), cur, 32'(ren_o[k]), 32'(e_ren[k][cur]));
                chk($sformatf("addr_%0d", k), cur, 32'(addr_o[k]), 32'(e_addr[k][cur]));
                chk($sformatf("wdata_%0d", k), cur, wdata_o[k], e_wdata[k][cur]);
                chk($sformatf("wstrb_%0d", k), cur, 32'(wstrb_o[k]), 32'(e_wstrb[k][cur]));
                chk($sformatf("dat_%0d", k), cur, dat_o[k], e_dat[k][cur]);
            end
            pins(cur);
        end
    end

    task automatic apply(input int n);
        rst_n       = s_rst[n];
        wb_cyc_i    = s_cyc[n];
        wb_stb_i    = s_stb[n];
        wb_we_i     = s_we[n];
        wb_sel_i    = s_sel[n];
        wb_adr_i    = s_adr[n];
        wb_dat_i    = s_dat[n];
        reg_rdata_i = s_rdata[n];
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cur = 0; running = 0; len = 0;
        for (int n = 0; n < N; n++) begin
            s_rst[n] = 1; s_cyc[n] = 0; s_stb[n] = 0; s_we[n] = 0;
            s_sel[n] = '0; s_adr[n] = '0; s_dat[n] = '0;
            s_rdata[n] = 32'h5A00_0000 ^ (32'(n) * 32'h0001_0203);
        end

        rst_cycles(2);                                   // 0-1
        idle(1);                                         // 2
        req(1, 32'h10, 32'hA5A5_1234, 4'hF, 2);          // 3-4
        idle(1);                                         // 5
        req(1, 32'h24, 32'h1122_3344, 4'b0100, 2);       // 6-7
        req(1, 32'h28, 32'h0, 4'h0, 2);                  // 8-9
        idle(1);                                         // 10
        req(0, 32'h100, 32'h0, 4'hF, 2);                 // 11-12
        req(1, 32'h8000_0010, 32'hDEAD_0001, 4'hF, 2);   // 13-14
        idle(1);                                         // 15
        req(0, 32'hC8, 32'h0, 4'hF, 2);                  // 16-17
        idle(6);                                         // 18-23
        req(0, 32'h08, 32'h0, 4'hF, 6);                  // 24-29
        idle(2);                                         // 30-31
        req(0, 32'h0C, 32'h0, 4'hF, 3);                  // 32-34
        idle(4);                                         // 35-38
        req(1, 32'h30, 32'h1, 4'hF, 2);                  // 39-40
        req(1, 32'h34, 32'h2, 4'h3, 2);                  // 41-42
        req(0, 32'h38, 32'h0, 4'hF, 6);                  // 43-48
        idle(2);                                         // 49-50
        req(0, 32'h04, 32'h0, 4'hF, 3);                  // 51-53
        idle(4);                                         // 54-57
        req(0, 32'h04, 32'h0, 4'hF, 6);                  // 58-63
        idle(1);                                         // 64
        req(0, 32'h14, 32'h0, 4'hF, 3);                  // 65-67
        rst_cycles(2);                                   // 68-69
        idle(2);                                         // 70-71
        req(1, 32'h3C, 32'h77, 4'hF, 2);                 // 72-73
        req(0, 32'h3C, 32'h0, 4'hF, 6);                  // 74-79
        req(1, 32'h20, 32'h55, 4'hF, 1);                 // 80
        idle(3);                                         // 81-83

        s_rdata[28] = 32'hDEAD_BEEF;
        s_rdata[33] = 32'hCAFE_F00D;

        build_model(0, 64, 3);
        build_model(1, 48, 0);

        apply(0);
        running = 1;
        for (int n = 1; n < N; n++) begin
            @(posedge clk);
            #1;
            apply(n);
            cur = n;
        end
        @(posedge clk);
        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
